// File: rtl/alu_op_issuer_pkg.sv
// rtl/alu_op_issuer_pkg.sv - shared ALUFun codes, MIPS opcode/funct values and issuer types
package alu_op_issuer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [5:0] FUN_ADD   = 6'b000000;
  localparam logic [5:0] FUN_SUB   = 6'b000001;
  localparam logic [5:0] FUN_AND   = 6'b011000;
  localparam logic [5:0] FUN_OR    = 6'b011110;
  localparam logic [5:0] FUN_XOR   = 6'b010110;
  localparam logic [5:0] FUN_NOR   = 6'b010001;
  localparam logic [5:0] FUN_PASSA = 6'b011010;
  localparam logic [5:0] FUN_SLL   = 6'b100000;
  localparam logic [5:0] FUN_SRL   = 6'b100001;
  localparam logic [5:0] FUN_SRA   = 6'b100011;
  localparam logic [5:0] FUN_EQ    = 6'b110011;
  localparam logic [5:0] FUN_NEQ   = 6'b110001;
  localparam logic [5:0] FUN_LT    = 6'b110101;
  localparam logic [5:0] FUN_LEZ   = 6'b111100;
  localparam logic [5:0] FUN_GEZ   = 6'b111000;
  localparam logic [5:0] FUN_GTZ   = 6'b111110;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_SLLV   = 6'h04;
  localparam logic [5:0] FN_SRLV   = 6'h06;
  localparam logic [5:0] FN_SRAV   = 6'h07;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUB    = 6'h22;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_XOR    = 6'h26;
  localparam logic [5:0] FN_NOR    = 6'h27;
  localparam logic [5:0] FN_SLT    = 6'h2A;
  localparam logic [5:0] FN_SLTU   = 6'h2B;

  localparam logic [4:0] RT_BGEZ   = 5'd1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic        branch;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational map of instruction and operands to ALU controls
module alu_decode
  import alu_op_issuer_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output dec_t        o_dec
);

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rt_f;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;

  assign w_op    = i_instr[31:26];
  assign w_rt_f  = i_instr[20:16];
  assign w_shamt = i_instr[10:6];
  assign w_funct = i_instr[5:0];
  assign w_imm   = i_instr[15:0];

  always_comb begin
    o_dec      = '0;
    o_dec.sign = 1'b1;
    case (w_op)
      OP_RTYPE: begin
        o_dec.a = i_rs;
        o_dec.b = i_rt;
        case (w_funct)
          FN_ADD, FN_ADDU: o_dec.fun = FUN_ADD;
          FN_SUB, FN_SUBU: o_dec.fun = FUN_SUB;
          FN_AND:          o_dec.fun = FUN_AND;
          FN_OR:           o_dec.fun = FUN_OR;
          FN_XOR:          o_dec.fun = FUN_XOR;
          FN_NOR:          o_dec.fun = FUN_NOR;
          FN_SLT, FN_SLTU: o_dec.fun = FUN_LT;
          FN_SLL: begin o_dec.fun = FUN_SLL; o_dec.a = {27'b0, w_shamt}; end
          FN_SRL: begin o_dec.fun = FUN_SRL; o_dec.a = {27'b0, w_shamt}; end
          FN_SRA: begin o_dec.fun = FUN_SRA; o_dec.a = {27'b0, w_shamt}; end
          FN_SLLV: begin o_dec.fun = FUN_SLL; o_dec.a = {27'b0, i_rs[4:0]}; end
          FN_SRLV: begin o_dec.fun = FUN_SRL; o_dec.a = {27'b0, i_rs[4:0]}; end
          FN_SRAV: begin o_dec.fun = FUN_SRA; o_dec.a = {27'b0, i_rs[4:0]}; end
          FN_JR, FN_JALR: begin o_dec.fun = FUN_PASSA; o_dec.b = '0; end
          default: o_dec.illegal = 1'b1;
        endcase
        if (w_funct == FN_ADDU || w_funct == FN_SUBU || w_funct == FN_SLTU)
          o_dec.sign = 1'b0;
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        o_dec.fun  = FUN_ADD;
        o_dec.a    = i_rs;
        o_dec.b    = sext16(w_imm);
        o_dec.sign = (w_op != OP_ADDIU);
      end
      OP_SLTI, OP_SLTIU: begin
        o_dec.fun  = FUN_LT;
        o_dec.a    = i_rs;
        o_dec.b    = sext16(w_imm);
        o_dec.sign = (w_op != OP_SLTIU);
      end
      OP_ANDI: begin
        o_dec.fun = FUN_AND;
        o_dec.a   = i_rs;
        o_dec.b   = zext16(w_imm);
      end
      // lui is an ALU left shift of the zero-extended immediate by 16
      OP_LUI: begin
        o_dec.fun = FUN_SLL;
        o_dec.a   = 32'd16;
        o_dec.b   = zext16(w_imm);
      end
      OP_BEQ, OP_BNE: begin
        o_dec.fun    = (w_op == OP_BEQ) ? FUN_EQ : FUN_NEQ;
        o_dec.a      = i_rs;
        o_dec.b      = i_rt;
        o_dec.branch = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        o_dec.fun    = (w_op == OP_BLEZ) ? FUN_LEZ : FUN_GTZ;
        o_dec.a      = i_rs;
        o_dec.branch = 1'b1;
      end
      OP_REGIMM: begin
        if (w_rt_f == RT_BGEZ) begin
          o_dec.fun    = FUN_GEZ;
          o_dec.a      = i_rs;
          o_dec.branch = 1'b1;
        end else begin
          o_dec.illegal = 1'b1;
        end
      end
      default: o_dec.illegal = 1'b1;
    endcase
    // illegal ops present all-zero controls so nothing stray leaks out
    if (o_dec.illegal) begin
      o_dec         = '0;
      o_dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - ALU issue stage: handshake in, drive ALU, capture and return result
module alu_op_issuer
  import alu_op_issuer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [5:0]       alu_fun,
  output logic             alu_sign,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_illegal,
  output logic             out_branch,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [31:0]      r_alu_a;
  logic [31:0]      r_alu_b;
  logic [5:0]       r_alu_fun;
  logic             r_alu_sign;
  logic [31:0]      r_result;
  logic             r_out_valid;
  logic             r_illegal;
  logic             r_branch;
  logic [CNT_W-1:0] r_op_count;

  dec_t w_dec;
  logic w_accept;

  alu_decode u_decode (
    .i_instr (in_instr),
    .i_rs    (in_rs),
    .i_rt    (in_rt),
    .o_dec   (w_dec)
  );

  assign in_ready = (r_state == ST_IDLE) || (r_state == ST_RESP && out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= '0;
      r_alu_sign  <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_branch    <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (r_out_valid && out_ready)
        r_op_count <= r_op_count + CNT_ONE;
      case (r_state)
        ST_EXEC: begin
          r_result    <= alu_result;
          r_out_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        default: begin
          if (r_state == ST_RESP && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
          // accept overrides the RESP->IDLE retire for back-to-back issue
          if (w_accept) begin
            if (w_dec.illegal) begin
              r_illegal   <= 1'b1;
              r_branch    <= 1'b0;
              r_result    <= '0;
              r_out_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_alu_a    <= w_dec.a;
              r_alu_b    <= w_dec.b;
              r_alu_fun  <= w_dec.fun;
              r_alu_sign <= w_dec.sign;
              r_illegal  <= 1'b0;
              r_branch   <= w_dec.branch;
              r_state    <= ST_EXEC;
            end
          end
        end
      endcase
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_fun     = r_alu_fun;
  assign alu_sign    = r_alu_sign;
  assign out_valid   = r_out_valid;
  assign out_result  = r_result;
  assign out_illegal = r_illegal;
  assign out_branch  = r_branch;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - directed self-checking bench for alu_op_issuer
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;
  logic        out_branch;
  logic [15:0] op_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_op_issuer #(.CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_fun     (alu_fun),
    .alu_sign    (alu_sign),
    .alu_result  (alu_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_illegal (out_illegal),
    .out_branch  (out_branch),
    .op_count    (op_count)
  );

  // Reference combinational ALU sitting on the far side of the ALUFun interface
  function automatic logic [31:0] alu_model(input logic [5:0] f, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
    case (f)
      6'b000000: return a + b;
      6'b000001: return a - b;
      6'b011000: return a & b;
      6'b011110: return a | b;
      6'b010110: return a ^ b;
      6'b010001: return ~(a | b);
      6'b011010: return a;
      6'b100000: return b << a[4:0];
      6'b100001: return b >> a[4:0];
      6'b100011: return $unsigned($signed(b) >>> a[4:0]);
      6'b110011: return {31'b0, a == b};
      6'b110001: return {31'b0, a != b};
      6'b110101: return {31'b0, s ? ($signed(a) < $signed(b)) : (a < b)};
      6'b111100: return {31'b0, $signed(a) <= 0};
      6'b111000: return {31'b0, $signed(a) >= 0};
      6'b111110: return {31'b0, $signed(a) > 0};
      default:   return 32'h0;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_fun, alu_sign, alu_a, alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1;
    in_instr = instr;
    in_rs    = rs;
    in_rt    = rt;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_rs     = 32'h0;
    in_rt     = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_op_count", {16'b0, op_count}, 32'd0);
    chk("rst_alu_fun", {26'b0, alu_fun}, 32'd0);

    // add $3,$1,$2
    out_ready = 1'b1;
    issue(32'h00221820, 32'd5, 32'd7);
    chk("add_fun", {26'b0, alu_fun}, 32'h00);
    chk("add_sign", {31'b0, alu_sign}, 32'd1);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_exec_valid", {31'b0, out_valid}, 32'd0);
    chk("add_exec_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_result", out_result, 32'd12);
    chk("add_branch", {31'b0, out_branch}, 32'd0);
    tick();
    chk("add_count", {16'b0, op_count}, 32'd1);
    chk("add_retired", {31'b0, out_valid}, 32'd0);

    // sra $3,$2,4
    issue(32'h00021903, 32'd0, 32'h80000000);
    chk("sra_a", alu_a, 32'd4);
    chk("sra_fun", {26'b0, alu_fun}, 32'h23);
    tick();
    chk("sra_result", out_result, 32'hF8000000);
    tick();

    // beq taken then not taken
    issue(32'h10220003, 32'd9, 32'd9);
    chk("beq_fun", {26'b0, alu_fun}, 32'h33);
    tick();
    chk("beq_branch", {31'b0, out_branch}, 32'd1);
    chk("beq_taken", out_result, 32'd1);
    tick();
    issue(32'h10220003, 32'd9, 32'd8);
    tick();
    chk("beq_not_taken", out_result, 32'd0);
    tick();
    chk("beq_count", {16'b0, op_count}, 32'd4);

    // illegal opcode 0x3F: response one cycle after accept, ALU controls untouched
    issue(32'hFC000000, 32'h1234, 32'h5678);
    chk("ill_valid", {31'b0, out_valid}, 32'd1);
    chk("ill_flag", {31'b0, out_illegal}, 32'd1);
    chk("ill_result", out_result, 32'd0);
    chk("ill_branch", {31'b0, out_branch}, 32'd0);
    chk("ill_alu_fun_held", {26'b0, alu_fun}, 32'h33);
    chk("ill_alu_a_held", alu_a, 32'd9);
    tick();
    chk("ill_count", {16'b0, op_count}, 32'd5);

    // addiu with negative immediate: unsigned, sign-extended B
    issue(32'h2422FFFF, 32'd10, 32'd0);
    chk("addiu_sign", {31'b0, alu_sign}, 32'd0);
    chk("addiu_b", alu_b, 32'hFFFFFFFF);
    tick();
    chk("addiu_result", out_result, 32'd9);
    chk("addiu_illegal", {31'b0, out_illegal}, 32'd0);
    tick();

    // lui $1,0xABCD
    issue(32'h3C01ABCD, 32'hDEAD, 32'd0);
    chk("lui_a", alu_a, 32'd16);
    chk("lui_b", alu_b, 32'h0000ABCD);
    chk("lui_fun", {26'b0, alu_fun}, 32'h20);
    tick();
    chk("lui_result", out_result, 32'hABCD0000);
    tick();
    chk("lui_count", {16'b0, op_count}, 32'd7);

    // backpressure with a pending second op, then back-to-back accept
    out_ready = 1'b0;
    issue(32'h00221820, 32'd1, 32'd2);
    in_valid = 1'b1;
    in_instr = 32'h00221822;
    in_rs    = 32'd10;
    in_rt    = 32'd3;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result", out_result, 32'd3);
      chk("bp_alu_fun", {26'b0, alu_fun}, 32'h00);
      tick();
    end
    chk("bp_count_held", {16'b0, op_count}, 32'd7);
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_fun", {26'b0, alu_fun}, 32'h01);
    chk("b2b_a", alu_a, 32'd10);
    chk("b2b_valid_low", {31'b0, out_valid}, 32'd0);
    chk("b2b_count", {16'b0, op_count}, 32'd8);
    tick();
    chk("b2b_result", out_result, 32'd7);
    tick();
    chk("b2b_count2", {16'b0, op_count}, 32'd9);

    // reset during EXEC drops the op
    issue(32'h00221820, 32'd4, 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_exec_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_exec_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_exec_count", {16'b0, op_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_resp", {31'b0, out_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
